fetch_unit: RTL and testbench

Instruction-fetch stage of the 9-bit CPU, sitting directly upstream of the control decoder. It owns the program counter and a run/halt state machine, and drives the instruction-ROM address. It also computes the next PC from the decoder's Jump, BranchEn, TargSel and Ack outputs plus the ALU branch condition. It counts executed instructions for program-length reporting.

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_target_lut.sv | 19 +
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding, PC width
// default and the jump/branch target table.
package fetch_pkg;

  localparam int PC_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [PC_W_DEF-1:0] T0 = 10'd0;
  localparam logic [PC_W_DEF-1:0] T1 = 10'd8;
  localparam logic [PC_W_DEF-1:0] T2 = 10'h3FC;
  localparam logic [PC_W_DEF-1:0] T3 = 10'd100;

  function automatic logic [PC_W_DEF-1:0] target_of(input logic [1:0] sel);
    logic [PC_W_DEF-1:0] val;
    val = T0;
    case (sel)
      2'd0: val = T0;
      2'd1: val = T1;
      2'd2: val = T2;
      2'd3: val = T3;
      default: val = T0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/fetch_target_lut.sv
// Combinational target lookup: TargSel index to PC-width target/offset.
// Entries are sign-extended so negative offsets stay negative at wider PC widths.
module fetch_target_lut
  import fetch_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [1:0]      i_sel,
  output logic [PC_W-1:0] o_target
);

  logic [PC_W_DEF-1:0] w_entry;

  always_comb begin
    w_entry  = target_of(i_sel);
    o_target = PC_W'($signed(w_entry));
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, run/halt sequencing, next-PC
// selection from decoder/ALU controls, and a saturating executed-instruction count.
//
// state | meaning
// IDLE  | out of reset, waiting for Start
// RUN   | one instruction retired per cycle
// HALT  | halt instruction seen, Done high, waiting for Start
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Jump,
  input  logic             BranchEn,
  input  logic             Taken,
  input  logic [1:0]       TargSel,
  input  logic             Ack,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstCnt
);

  fetch_state_t     r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_running;
  logic             r_done;

  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_pc_next;
  logic [CNT_W-1:0] w_cnt_next;

  fetch_target_lut #(.PC_W(PC_W)) u_lut (
    .i_sel    (TargSel),
    .o_target (w_target)
  );

  // Modulo-2^PC_W arithmetic: adding the sign-extended offset wraps both ways.
  always_comb begin
    w_pc_next = r_pc + PC_W'(1);
    if (Jump)
      w_pc_next = w_target;
    else if (BranchEn && Taken)
      w_pc_next = r_pc + w_target;
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (r_cnt != {CNT_W{1'b1}})
      w_cnt_next = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HALT: begin
          if (Start) begin
            r_state   <= RUN;
            r_pc      <= StartAddr;
            r_cnt     <= '0;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        RUN: begin
          r_cnt <= w_cnt_next;
          if (Ack) begin
            r_state   <= HALT;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_pc <= w_pc_next;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign ProgCtr = r_pc;
  assign Running = r_running;
  assign Done    = r_done;
  assign InstCnt = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; a second instance with a 4-bit counter
// covers instruction-count saturation.
module tb_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [9:0]  StartAddr;
  logic        Jump;
  logic        BranchEn;
  logic        Taken;
  logic [1:0]  TargSel;
  logic        Ack;
  logic [9:0]  ProgCtr;
  logic        Running;
  logic        Done;
  logic [15:0] InstCnt;
  logic [9:0]  s_ProgCtr;
  logic        s_Running;
  logic        s_Done;
  logic [3:0]  s_InstCnt;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.PC_W(10), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Jump(Jump), .BranchEn(BranchEn), .Taken(Taken), .TargSel(TargSel),
    .Ack(Ack), .ProgCtr(ProgCtr), .Running(Running), .Done(Done),
    .InstCnt(InstCnt)
  );

  fetch_unit #(.PC_W(10), .CNT_W(4)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .Jump(Jump), .BranchEn(BranchEn), .Taken(Taken), .TargSel(TargSel),
    .Ack(Ack), .ProgCtr(s_ProgCtr), .Running(s_Running), .Done(s_Done),
    .InstCnt(s_InstCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Halts the program if needed, then starts at addr; returns 1 ns after the start edge.
  task automatic go(input logic [9:0] addr);
    if (Running) begin
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
    end
    StartAddr = addr;
    Start     = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #3;
    n_checks++; if (ProgCtr !== 10'd0) begin n_fail++; $display("FAIL reset_pc got %0d want 0", ProgCtr); end
    n_checks++; if (Running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b want 0", Running); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", Done); end
    n_checks++; if (InstCnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", InstCnt); end
    #9 Reset = 1'b1;
    tick();
    tick();
    n_checks++; if (Running !== 1'b0 || ProgCtr !== 10'd0) begin n_fail++; $display("FAIL idle_hold got run=%b pc=%0d want run=0 pc=0", Running, ProgCtr); end
    go(10'd25);
    repeat (12) tick();
    n_checks++; if (ProgCtr !== 10'd37 || InstCnt !== 16'd12) begin n_fail++; $display("FAIL pre_reset got pc=%0d cnt=%0d want pc=37 cnt=12", ProgCtr, InstCnt); end
    #2 Reset = 1'b0;
    #1;
    n_checks++; if (ProgCtr !== 10'd0 || InstCnt !== 16'd0 || Running !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got pc=%0d cnt=%0d run=%b done=%b want 0/0/0/0", ProgCtr, InstCnt, Running, Done);
    end
    #1 Reset = 1'b1;
    tick();
  endtask

  task automatic test_sequential();
    go(10'd5);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (ProgCtr !== 10'(5 + i)) begin n_fail++; $display("FAIL seq_pc[%0d] got %0d want %0d", i, ProgCtr, 5 + i); end
      tick();
    end
    n_checks++; if (InstCnt !== 16'd4) begin n_fail++; $display("FAIL seq_cnt got %0d want 4", InstCnt); end
    n_checks++; if (Running !== 1'b1 || Done !== 1'b0) begin n_fail++; $display("FAIL seq_state got run=%b done=%b want 1/0", Running, Done); end
  endtask

  task automatic test_jump_branch();
    go(10'd20);
    Jump = 1'b1; TargSel = 2'd3;
    tick();
    Jump = 1'b0;
    n_checks++; if (ProgCtr !== 10'd100) begin n_fail++; $display("FAIL jump_t3 got %0d want 100", ProgCtr); end
    Jump = 1'b1; TargSel = 2'd1;
    tick();
    Jump = 1'b0;
    n_checks++; if (ProgCtr !== 10'd8) begin n_fail++; $display("FAIL jump_t1 got %0d want 8", ProgCtr); end

    go(10'd50);
    BranchEn = 1'b1; Taken = 1'b1; TargSel = 2'd2;
    tick();
    BranchEn = 1'b0; Taken = 1'b0;
    n_checks++; if (ProgCtr !== 10'd46) begin n_fail++; $display("FAIL branch_taken got %0d want 46", ProgCtr); end

    go(10'd50);
    BranchEn = 1'b1; Taken = 1'b0; TargSel = 2'd2;
    tick();
    BranchEn = 1'b0;
    n_checks++; if (ProgCtr !== 10'd51) begin n_fail++; $display("FAIL branch_not_taken got %0d want 51", ProgCtr); end

    Taken = 1'b1;
    tick();
    Taken = 1'b0;
    n_checks++; if (ProgCtr !== 10'd52) begin n_fail++; $display("FAIL taken_no_en got %0d want 52", ProgCtr); end

    Start = 1'b1; StartAddr = 10'd0;
    tick();
    Start = 1'b0;
    n_checks++; if (ProgCtr !== 10'd53 || InstCnt !== 16'd3) begin n_fail++; $display("FAIL start_in_run got pc=%0d cnt=%0d want pc=53 cnt=3", ProgCtr, InstCnt); end
  endtask

  task automatic test_wrap();
    go(10'd1023);
    tick();
    n_checks++; if (ProgCtr !== 10'd0) begin n_fail++; $display("FAIL wrap_inc got %0d want 0", ProgCtr); end
    go(10'd2);
    BranchEn = 1'b1; Taken = 1'b1; TargSel = 2'd2;
    tick();
    n_checks++; if (ProgCtr !== 10'd1022) begin n_fail++; $display("FAIL wrap_back got %0d want 1022", ProgCtr); end
    BranchEn = 1'b0; Taken = 1'b0;
    go(10'd1000);
    BranchEn = 1'b1; Taken = 1'b1; TargSel = 2'd3;
    tick();
    BranchEn = 1'b0; Taken = 1'b0;
    n_checks++; if (ProgCtr !== 10'd76) begin n_fail++; $display("FAIL wrap_fwd got %0d want 76", ProgCtr); end
  endtask

  task automatic test_halt();
    go(10'd9);
    Ack = 1'b1; Jump = 1'b1; TargSel = 2'd3;
    tick();
    Ack = 1'b0;
    n_checks++; if (ProgCtr !== 10'd9) begin n_fail++; $display("FAIL halt_pc got %0d want 9", ProgCtr); end
    n_checks++; if (Done !== 1'b1 || Running !== 1'b0) begin n_fail++; $display("FAIL halt_state got run=%b done=%b want 0/1", Running, Done); end
    n_checks++; if (InstCnt !== 16'd1) begin n_fail++; $display("FAIL halt_cnt got %0d want 1", InstCnt); end
    BranchEn = 1'b1; Taken = 1'b1;
    tick(); tick();
    Jump = 1'b0; BranchEn = 1'b0; Taken = 1'b0;
    n_checks++; if (ProgCtr !== 10'd9 || Done !== 1'b1 || InstCnt !== 16'd1) begin
      n_fail++; $display("FAIL halt_hold got pc=%0d done=%b cnt=%0d want 9/1/1", ProgCtr, Done, InstCnt);
    end
    StartAddr = 10'd0; Start = 1'b1;
    tick();
    Start = 1'b0;
    n_checks++; if (ProgCtr !== 10'd0 || InstCnt !== 16'd0 || Done !== 1'b0 || Running !== 1'b1) begin
      n_fail++; $display("FAIL restart got pc=%0d cnt=%0d done=%b run=%b want 0/0/0/1", ProgCtr, InstCnt, Done, Running);
    end
  endtask

  task automatic test_ack_with_start();
    go(10'd30);
    Ack = 1'b1; Start = 1'b1; StartAddr = 10'd7;
    tick();
    Ack = 1'b0;
    n_checks++; if (Done !== 1'b1 || Running !== 1'b0 || ProgCtr !== 10'd30) begin
      n_fail++; $display("FAIL ack_start_halt got done=%b run=%b pc=%0d want 1/0/30", Done, Running, ProgCtr);
    end
    tick();
    Start = 1'b0;
    n_checks++; if (Running !== 1'b1 || Done !== 1'b0 || ProgCtr !== 10'd7) begin
      n_fail++; $display("FAIL ack_start_restart got run=%b done=%b pc=%0d want 1/0/7", Running, Done, ProgCtr);
    end
  endtask

  task automatic test_saturation();
    go(10'd200);
    repeat (15) tick();
    n_checks++; if (s_InstCnt !== 4'd15) begin n_fail++; $display("FAIL sat_reach got %0d want 15", s_InstCnt); end
    repeat (5) tick();
    n_checks++; if (s_InstCnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d want 15", s_InstCnt); end
    n_checks++; if (InstCnt !== 16'd20) begin n_fail++; $display("FAIL wide_cnt got %0d want 20", InstCnt); end
    n_checks++; if (s_ProgCtr !== 10'd220 || s_Running !== 1'b1 || s_Done !== 1'b0) begin
      n_fail++; $display("FAIL sat_pc got pc=%0d run=%b done=%b want 220/1/0", s_ProgCtr, s_Running, s_Done);
    end
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; StartAddr = '0; Jump = 1'b0;
    BranchEn = 1'b0; Taken = 1'b0; TargSel = 2'd0; Ack = 1'b0;
    test_reset();
    test_sequential();
    test_jump_branch();
    test_wrap();
    test_halt();
    test_ack_with_start();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
